// File: rtl/iicmb_txn_sequencer_if.sv
// Request/response handshake plus the Wishbone and irq lines between the
// transfer sequencer and its host/IICMB environment.
interface iicmb_txn_sequencer_if #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_op;
  logic [7:0]                req_bus_id;
  logic [I2C_ADDR_WIDTH-1:0] req_slave_addr;
  logic [WB_DATA_WIDTH-1:0]  req_wdata;

  logic                      rsp_valid;
  logic [WB_DATA_WIDTH-1:0]  rsp_rdata;
  logic [1:0]                rsp_status;

  logic                      cyc_o;
  logic                      stb_o;
  logic                      we_o;
  logic [WB_ADDR_WIDTH-1:0]  adr_o;
  logic [WB_DATA_WIDTH-1:0]  dat_o;
  logic [WB_DATA_WIDTH-1:0]  dat_i;
  logic                      ack_i;
  logic                      irq_i;

  modport master (
    input  req_valid, req_op, req_bus_id, req_slave_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_status,
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i, irq_i
  );

  modport slave (
    output req_valid, req_op, req_bus_id, req_slave_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_status,
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i, irq_i
  );
endinterface

// File: rtl/iicmb_txn_sequencer.sv
// Wishbone master that drives the IICMB controller through one complete
// single-byte I2C write or read and reports the read byte and status.
module iicmb_txn_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int IRQ_TIMEOUT    = 65535
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  iicmb_txn_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_EN, S_IDLE,
    S_SETBUS_DPR, S_SETBUS_CMD, S_START_CMD,
    S_ADDR_DPR, S_ADDR_CMD, S_DATA_DPR, S_DATA_CMD,
    S_RDNAK_CMD, S_RD_DPR, S_STOP_CMD,
    S_CW_IRQ, S_CW_READ, S_RSP
  } state_e;

  typedef enum logic [2:0] {
    PH_SETBUS, PH_START, PH_ADDR, PH_DATA, PH_RDNAK, PH_STOP
  } phase_e;

  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

  localparam logic [WB_DATA_WIDTH-1:0] CSR_ENABLE   = WB_DATA_WIDTH'(8'hC0);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_SETBUS   = WB_DATA_WIDTH'(8'h06);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_START    = WB_DATA_WIDTH'(8'h04);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_WRITE    = WB_DATA_WIDTH'(8'h01);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_READ_NAK = WB_DATA_WIDTH'(8'h03);
  localparam logic [WB_DATA_WIDTH-1:0] CMD_STOP     = WB_DATA_WIDTH'(8'h05);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_NAK = 2'b01;
  localparam logic [1:0] ST_ERR = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  localparam logic [15:0] TMO_LAST = 16'(IRQ_TIMEOUT - 1);

  state_e                    state_q, state_d;
  phase_e                    phase_q, phase_d;
  logic [1:0]                status_q, status_d;
  logic [WB_DATA_WIDTH-1:0]  rdByte_q, rdByte_d;
  logic                      gap_q;
  logic [15:0]               tmoCnt_q;

  logic                      op_q;
  logic [7:0]                busId_q;
  logic [I2C_ADDR_WIDTH-1:0] slaveAddr_q;
  logic [WB_DATA_WIDTH-1:0]  wdata_q;
  logic [WB_DATA_WIDTH-1:0]  rspRdata_q;
  logic [1:0]                rspStatus_q;

  logic                      accReq;
  logic                      accWe;
  logic [WB_ADDR_WIDTH-1:0]  accAdr;
  logic [WB_DATA_WIDTH-1:0]  accDat;
  logic                      wbCyc;
  logic                      wbAck;
  logic                      accept;

  // gap_q forces one idle cycle after every acknowledged access
  assign wbCyc  = accReq && !gap_q;
  assign wbAck  = wbCyc && bus.ack_i;
  assign accept = (state_q == S_IDLE) && bus.req_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_EN;
      phase_q  <= PH_SETBUS;
      status_q <= ST_OK;
      rdByte_q <= '0;
      gap_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      status_q <= status_d;
      rdByte_q <= rdByte_d;
      gap_q    <= wbAck;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    status_d = status_q;
    rdByte_d = rdByte_q;
    case (state_q)
      S_EN:         if (wbAck) state_d = S_IDLE;
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d  = S_SETBUS_DPR;
          status_d = ST_OK;
          rdByte_d = '0;
        end
      end
      S_SETBUS_DPR: if (wbAck) state_d = S_SETBUS_CMD;
      S_SETBUS_CMD: if (wbAck) begin state_d = S_CW_IRQ; phase_d = PH_SETBUS; end
      S_START_CMD:  if (wbAck) begin state_d = S_CW_IRQ; phase_d = PH_START;  end
      S_ADDR_DPR:   if (wbAck) state_d = S_ADDR_CMD;
      S_ADDR_CMD:   if (wbAck) begin state_d = S_CW_IRQ; phase_d = PH_ADDR;   end
      S_DATA_DPR:   if (wbAck) state_d = S_DATA_CMD;
      S_DATA_CMD:   if (wbAck) begin state_d = S_CW_IRQ; phase_d = PH_DATA;   end
      S_RDNAK_CMD:  if (wbAck) begin state_d = S_CW_IRQ; phase_d = PH_RDNAK;  end
      S_STOP_CMD:   if (wbAck) begin state_d = S_CW_IRQ; phase_d = PH_STOP;   end
      S_RD_DPR: begin
        if (wbAck) begin
          rdByte_d = bus.dat_i;
          state_d  = S_STOP_CMD;
        end
      end
      S_CW_IRQ: begin
        if (bus.irq_i) begin
          state_d = S_CW_READ;
        end else if (tmoCnt_q == TMO_LAST) begin
          if (status_q == ST_OK) status_d = ST_TMO;
          state_d = (phase_q == PH_STOP) ? S_RSP : S_STOP_CMD;
        end
      end
      // A CMDR value with no error bits is taken as DON
      S_CW_READ: begin
        if (wbAck) begin
          if (bus.dat_i[5] || bus.dat_i[4]) begin
            if (status_q == ST_OK) status_d = ST_ERR;
            state_d = S_RSP;
          end else if (phase_q == PH_STOP) begin
            state_d = S_RSP;
          end else if (bus.dat_i[6]) begin
            if (status_q == ST_OK) status_d = ST_NAK;
            state_d = S_STOP_CMD;
          end else begin
            case (phase_q)
              PH_SETBUS: state_d = S_START_CMD;
              PH_START:  state_d = S_ADDR_DPR;
              PH_ADDR:   state_d = op_q ? S_RDNAK_CMD : S_DATA_DPR;
              PH_DATA:   state_d = S_STOP_CMD;
              PH_RDNAK:  state_d = S_RD_DPR;
              default:   state_d = S_RSP;
            endcase
          end
        end
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_EN;
    endcase
  end

  always_comb begin
    accReq = 1'b0;
    accWe  = 1'b0;
    accAdr = ADR_CSR;
    accDat = '0;
    case (state_q)
      S_EN:         begin accReq = 1'b1; accWe = 1'b1; accAdr = ADR_CSR;  accDat = CSR_ENABLE; end
      S_SETBUS_DPR: begin accReq = 1'b1; accWe = 1'b1; accAdr = ADR_DPR;  accDat = WB_DATA_WIDTH'(busId_q); end
      S_SETBUS_CMD: begin accReq = 1'b1; accWe = 1'b1; accAdr = ADR_CMDR; accDat = CMD_SETBUS; end
      S_START_CMD:  begin accReq = 1'b1; accWe = 1'b1; accAdr = ADR_CMDR; accDat = CMD_START; end
      S_ADDR_DPR:   begin accReq = 1'b1; accWe = 1'b1; accAdr = ADR_DPR;  accDat = WB_DATA_WIDTH'({slaveAddr_q, op_q}); end
      S_ADDR_CMD:   begin accReq = 1'b1; accWe = 1'b1; accAdr = ADR_CMDR; accDat = CMD_WRITE; end
      S_DATA_DPR:   begin accReq = 1'b1; accWe = 1'b1; accAdr = ADR_DPR;  accDat = wdata_q; end
      S_DATA_CMD:   begin accReq = 1'b1; accWe = 1'b1; accAdr = ADR_CMDR; accDat = CMD_WRITE; end
      S_RDNAK_CMD:  begin accReq = 1'b1; accWe = 1'b1; accAdr = ADR_CMDR; accDat = CMD_READ_NAK; end
      S_STOP_CMD:   begin accReq = 1'b1; accWe = 1'b1; accAdr = ADR_CMDR; accDat = CMD_STOP; end
      S_RD_DPR:     begin accReq = 1'b1; accAdr = ADR_DPR; end
      S_CW_READ:    begin accReq = 1'b1; accAdr = ADR_CMDR; end
      default:      accReq = 1'b0;
    endcase
  end

  // Request fields, irq watchdog and the held response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q        <= 1'b0;
      busId_q     <= '0;
      slaveAddr_q <= '0;
      wdata_q     <= '0;
      tmoCnt_q    <= '0;
      rspRdata_q  <= '0;
      rspStatus_q <= ST_OK;
    end else begin
      if (accept) begin
        op_q        <= bus.req_op;
        busId_q     <= bus.req_bus_id;
        slaveAddr_q <= bus.req_slave_addr;
        wdata_q     <= bus.req_wdata;
      end
      tmoCnt_q <= (state_q == S_CW_IRQ) ? tmoCnt_q + 16'd1 : 16'd0;
      if (state_d == S_RSP && state_q != S_RSP) begin
        rspStatus_q <= status_d;
        rspRdata_q  <= (status_d == ST_OK && op_q) ? rdByte_q : '0;
      end
    end
  end

  assign bus.cyc_o      = wbCyc;
  assign bus.stb_o      = wbCyc;
  assign bus.we_o       = wbCyc && accWe;
  assign bus.adr_o      = wbCyc ? accAdr : '0;
  assign bus.dat_o      = (wbCyc && accWe) ? accDat : '0;
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = (state_q == S_RSP);
  assign bus.rsp_rdata  = rspRdata_q;
  assign bus.rsp_status = rspStatus_q;

endmodule

// File: tb/tb_iicmb_txn_sequencer.sv
// Self-checking bench: an IICMB register model answers the Wishbone side and a
// transaction-level model predicts the access list, status and read byte.
module tb_iicmb_txn_sequencer;

  typedef struct packed {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
  } acc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iicmb_txn_sequencer_if #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .I2C_ADDR_WIDTH(7)) bus ();

  iicmb_txn_sequencer #(
    .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .I2C_ADDR_WIDTH(7), .IRQ_TIMEOUT(65535)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle++;

  // Environment configuration: 0 none, 1 NAK addr, 2 NAK data, 3 bus ERR, 4 AL at start
  int         fault     = 0;
  bit         stopErr   = 1'b0;
  int         noIrqIdx  = -1;
  logic [7:0] rdByte    = 8'h00;
  int         cmdIdx    = 0;
  int         wrSinceStart = 0;
  int         gapViol   = 0;
  logic [7:0] pendStat  = 8'h00;

  acc_t logQ[$];
  int   logCyc[$];
  acc_t expQ[$];

  // IICMB register model with single-cycle ack and immediate irq
  always @(negedge clk) begin
    acc_t a;
    if (rst) begin
      bus.ack_i = 1'b0;
      bus.irq_i = 1'b0;
      bus.dat_i = 8'h00;
    end else if (bus.ack_i) begin
      if (bus.cyc_o) gapViol++;
      bus.ack_i = 1'b0;
    end else if (bus.cyc_o && bus.stb_o) begin
      bus.ack_i = 1'b1;
      a.we  = bus.we_o;
      a.adr = bus.adr_o;
      a.dat = bus.we_o ? bus.dat_o : 8'h00;
      logQ.push_back(a);
      logCyc.push_back(cycle);
      if (bus.we_o && bus.adr_o == 2'd2) begin
        case (bus.dat_o)
          8'h06: pendStat = (fault == 3) ? 8'h10 : 8'h80;
          8'h04: begin pendStat = (fault == 4) ? 8'h20 : 8'h80; wrSinceStart = 0; end
          8'h01: begin
            pendStat = ((wrSinceStart == 0 && fault == 1) || (wrSinceStart == 1 && fault == 2)) ? 8'h40 : 8'h80;
            wrSinceStart++;
          end
          8'h05:   pendStat = stopErr ? 8'h10 : 8'h80;
          default: pendStat = 8'h80;
        endcase
        if (cmdIdx != noIrqIdx) bus.irq_i = 1'b1;
        cmdIdx++;
      end else if (!bus.we_o && bus.adr_o == 2'd2) begin
        bus.dat_i = pendStat;
        bus.irq_i = 1'b0;
      end else if (!bus.we_o && bus.adr_o == 2'd1) begin
        bus.dat_i = rdByte;
      end
    end
  end

  task automatic pushW(input logic [1:0] adr, input logic [7:0] dat);
    acc_t a;
    a.we = 1'b1; a.adr = adr; a.dat = dat;
    expQ.push_back(a);
  endtask

  task automatic pushR(input logic [1:0] adr);
    acc_t a;
    a.we = 1'b0; a.adr = adr; a.dat = 8'h00;
    expQ.push_back(a);
  endtask

  // Outcome of one command: 0 done, 1 NAK, 2 AL/ERR, 3 no irq
  task automatic issue(input logic [7:0] cmd, input int kind, inout int idx, output int o);
    pushW(2'd2, cmd);
    if (idx == noIrqIdx) begin
      o = 3;
    end else begin
      pushR(2'd2);
      case (kind)
        0:       o = (fault == 3) ? 2 : 0;
        1:       o = (fault == 4) ? 2 : 0;
        2:       o = (fault == 1) ? 1 : 0;
        3:       o = (fault == 2) ? 1 : 0;
        5:       o = stopErr ? 2 : 0;
        default: o = 0;
      endcase
    end
    idx++;
  endtask

  task automatic buildExpected(input logic op, input logic [7:0] busId, input logic [6:0] addr,
                               input logic [7:0] wd, output logic [1:0] st, output logic [7:0] rd);
    int  idx = 0;
    int  o;
    bit  abort = 1'b0;
    st = 2'd0;
    pushW(2'd1, busId);
    issue(8'h06, 0, idx, o);
    if (o == 2) begin st = 2'd2; abort = 1'b1; end else if (o == 3) st = 2'd3;
    if (!abort && st == 0) begin
      issue(8'h04, 1, idx, o);
      if (o == 2) begin st = 2'd2; abort = 1'b1; end else if (o == 3) st = 2'd3;
    end
    if (!abort && st == 0) begin
      pushW(2'd1, {addr, op});
      issue(8'h01, 2, idx, o);
      if (o == 1) st = 2'd1; else if (o == 3) st = 2'd3;
    end
    if (!abort && st == 0) begin
      if (!op) begin
        pushW(2'd1, wd);
        issue(8'h01, 3, idx, o);
        if (o == 1) st = 2'd1; else if (o == 3) st = 2'd3;
      end else begin
        issue(8'h03, 4, idx, o);
        if (o == 3) st = 2'd3; else pushR(2'd1);
      end
    end
    if (!abort) begin
      issue(8'h05, 5, idx, o);
      if (st == 0 && o == 2) st = 2'd2;
      else if (st == 0 && o == 3) st = 2'd3;
    end
    rd = (op && st == 0) ? rdByte : 8'h00;
  endtask

  task automatic doTxn(input string name, input logic op, input logic [7:0] busId,
                       input logic [6:0] addr, input logic [7:0] wd, input int budget);
    logic [1:0] expSt, gotSt;
    logic [7:0] expRd, gotRd;
    int n;
    bit seen;
    @(negedge clk);
    logQ.delete(); logCyc.delete(); expQ.delete();
    cmdIdx = 0; gapViol = 0;
    buildExpected(op, busId, addr, wd, expSt, expRd);
    n = 0;
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!bus.req_ready) begin
      errors++;
      $display("[TB] FAIL %s ready_wait: req_ready=%b required 1", name, bus.req_ready);
      return;
    end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_bus_id = busId;
    bus.req_slave_addr = addr; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op = 1'($urandom); bus.req_bus_id = 8'($urandom);
    bus.req_slave_addr = 7'($urandom); bus.req_wdata = 8'($urandom);
    seen = 1'b0; n = 0; gotSt = 2'd0; gotRd = 8'd0;
    while (!seen && n < budget) begin
      if (bus.rsp_valid) begin
        seen = 1'b1; gotSt = bus.rsp_status; gotRd = bus.rsp_rdata;
      end else begin
        @(negedge clk); n++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s rsp_seen: no rsp_valid within %0d cycles", name, budget);
      return;
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_status !== gotSt) begin
      errors++;
      $display("[TB] FAIL %s rsp_pulse: rsp_valid=%b status=%b required 0 and held %b",
               name, bus.rsp_valid, bus.rsp_status, gotSt);
    end
    checks++;
    if (gotSt !== expSt) begin
      errors++;
      $display("[TB] FAIL %s status: got %b expected %b", name, gotSt, expSt);
    end
    checks++;
    if (gotRd !== expRd) begin
      errors++;
      $display("[TB] FAIL %s rdata: got %h expected %h", name, gotRd, expRd);
    end
    checks++;
    if (logQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL %s access_count: got %0d expected %0d", name, logQ.size(), expQ.size());
    end
    for (int i = 0; i < logQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (logQ[i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL %s access[%0d]: got we=%b adr=%0d dat=%h expected we=%b adr=%0d dat=%h",
                 name, i, logQ[i].we, logQ[i].adr, logQ[i].dat, expQ[i].we, expQ[i].adr, expQ[i].dat);
      end
    end
    checks++;
    if (gapViol != 0) begin
      errors++;
      $display("[TB] FAIL %s wb_idle_gap: %0d accesses held cyc after ack, required 0", name, gapViol);
    end
  endtask

  task automatic waitReadyAfterReset(input string name);
    int n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!bus.req_ready) begin
      errors++;
      $display("[TB] FAIL %s enable_ready: req_ready=%b required 1", name, bus.req_ready);
    end
    checks++;
    if (logQ.size() != 1 || logQ[0] !== acc_t'({1'b1, 2'd0, 8'hC0})) begin
      errors++;
      $display("[TB] FAIL %s enable_write: got %0d accesses, first %h, required one write adr0 C0",
               name, logQ.size(), (logQ.size() > 0) ? logQ[0] : acc_t'(0));
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checks++;
    if ({bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL %s wb_reset: cyc=%b stb=%b we=%b adr=%0d dat=%h required all 0",
               name, bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o);
    end
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_rdata} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL %s host_reset: ready=%b valid=%b status=%b rdata=%h required all 0",
               name, bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    logQ.delete(); logCyc.delete();
    rst = 1'b0;
    waitReadyAfterReset("reset");
  endtask

  task automatic test_write();
    fault = 0; stopErr = 0; noIrqIdx = -1;
    doTxn("write", 1'b0, 8'h00, 7'h22, 8'h5A, 200);
    checks++;
    if (logQ.size() < 6 || logQ[5] !== acc_t'({1'b1, 2'd1, 8'h44})) begin
      errors++;
      $display("[TB] FAIL write addr_byte: got %h required write adr1 44",
               (logQ.size() > 5) ? logQ[5] : acc_t'(0));
    end
  endtask

  task automatic test_read();
    fault = 0; stopErr = 0; noIrqIdx = -1; rdByte = 8'h64;
    doTxn("read", 1'b1, 8'h00, 7'h22, 8'h00, 200);
    checks++;
    if (logQ.size() < 6 || logQ[5] !== acc_t'({1'b1, 2'd1, 8'h45})) begin
      errors++;
      $display("[TB] FAIL read addr_byte: got %h required write adr1 45",
               (logQ.size() > 5) ? logQ[5] : acc_t'(0));
    end
  endtask

  task automatic test_nak();
    fault = 1; stopErr = 0; noIrqIdx = -1;
    doTxn("nak_addr", 1'b0, 8'h01, 7'h22, 8'hA5, 200);
    fault = 2; stopErr = 1;
    doTxn("nak_data_stop_err", 1'b0, 8'h02, 7'h31, 8'h3C, 200);
    fault = 3; stopErr = 0;
    doTxn("setbus_err", 1'b1, 8'hFF, 7'h10, 8'h00, 200);
    fault = 4;
    doTxn("start_al", 1'b0, 8'h00, 7'h50, 8'h11, 200);
    fault = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fault = 0; stopErr = 0; noIrqIdx = 3;
    @(negedge clk);
    logQ.delete(); cmdIdx = 0;
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.req_bus_id = 8'h00;
    bus.req_slave_addr = 7'h22; bus.req_wdata = 8'h5A;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (logQ.size() < 10 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (logQ.size() < 10) begin
      errors++;
      $display("[TB] FAIL reset_mid reach_data_wait: got %0d accesses required 10", logQ.size());
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("reset_mid");
    logQ.delete(); logCyc.delete();
    noIrqIdx = -1;
    rst = 1'b0;
    waitReadyAfterReset("reset_mid");
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      fault    = int'($urandom_range(0, 4));
      stopErr  = ($urandom_range(0, 3) == 0);
      noIrqIdx = -1;
      rdByte   = 8'($urandom);
      doTxn($sformatf("random%0d", t), 1'($urandom), 8'($urandom), 7'($urandom), 8'($urandom), 200);
    end
    fault = 0; stopErr = 0;
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      rdByte = 8'($urandom);
      doTxn($sformatf("b2b%0d", t), t[0], 8'(t), 7'($urandom), 8'($urandom), 200);
    end
  endtask

  task automatic test_timeout();
    int d;
    fault = 0; stopErr = 0; noIrqIdx = 1;
    doTxn("timeout_start", 1'b0, 8'h00, 7'h22, 8'h5A, 70000);
    checks++;
    d = (logCyc.size() >= 5) ? logCyc[4] - logCyc[3] : -1;
    if (d < 65530 || d > 65545) begin
      errors++;
      $display("[TB] FAIL timeout_delay: START to STOP took %0d cycles required about 65536", d);
    end
    noIrqIdx = -1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_bus_id = 8'h00;
    bus.req_slave_addr = 7'h00; bus.req_wdata = 8'h00;
    bus.ack_i = 1'b0; bus.irq_i = 1'b0; bus.dat_i = 8'h00;
    test_reset();
    test_write();
    test_nak();
    test_read();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
